// File: rtl/in_fifo_gearbox.sv
// Single-clock channel FIFO with optional 2:1 beat packing, almost flags,
// occupancy count and sticky overflow/underflow flags.
module in_fifo_gearbox #(
  parameter int NUM_CH             = 10,
  parameter int IN_WIDTH           = 4,
  parameter int RATIO              = 2,
  parameter int DEPTH              = 8,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1
) (
  input  logic                                CLK,
  input  logic                                RESET_N,
  input  logic                                WREN,
  input  logic [NUM_CH*IN_WIDTH-1:0]          D,
  input  logic                                RDEN,
  input  logic                                CLR_ERR,
  output logic [NUM_CH*IN_WIDTH*RATIO-1:0]    Q,
  output logic                                EMPTY,
  output logic                                ALMOSTEMPTY,
  output logic                                FULL,
  output logic                                ALMOSTFULL,
  output logic [$clog2(DEPTH):0]              COUNT,
  output logic                                WR_HALF,
  output logic                                OVERFLOW,
  output logic                                UNDERFLOW
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int DW        = NUM_CH * IN_WIDTH;
  localparam int QW        = NUM_CH * OUT_WIDTH;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;

  generate
    if (NUM_CH < 1 || NUM_CH > 16 || IN_WIDTH < 1 || IN_WIDTH > 8 ||
        (RATIO != 1 && RATIO != 2) || DEPTH < 4 || DEPTH > 64 ||
        ((DEPTH & (DEPTH - 1)) != 0) ||
        ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH - 2 ||
        ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH - 2) begin : g_bad_param
      $fatal(1, "%m: attribute error, illegal parameter value");
    end
  endgenerate

  // Handshake: a write beat is taken when WREN && !FULL, a read when
  // RDEN && !EMPTY, both sampled before the edge; refused requests only
  // raise the matching sticky error flag and change no stored state.
  logic              wr_acc;
  logic              rd_acc;
  logic              commit;
  logic [QW-1:0]     entry;
  logic [QW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;

  assign wr_acc = WREN & ~FULL;
  assign rd_acc = RDEN & ~EMPTY;

  generate
    if (RATIO == 2) begin : g_pack
      logic [DW-1:0] hold;
      logic          half;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          hold <= '0;
          half <= 1'b0;
        end else if (wr_acc) begin
          if (!half) hold <= D;
          half <= ~half;
        end
      end

      // Second beat lands in the upper half of each channel slice.
      always_comb begin
        entry = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          entry[c*OUT_WIDTH +: OUT_WIDTH] = {D[c*IN_WIDTH +: IN_WIDTH],
                                             hold[c*IN_WIDTH +: IN_WIDTH]};
        end
      end

      assign commit  = wr_acc & half;
      assign WR_HALF = half;
    end else begin : g_direct
      assign entry   = D;
      assign commit  = wr_acc;
      assign WR_HALF = 1'b0;
    end
  endgenerate

  assign count_nxt = COUNT + CW'(commit) - CW'(rd_acc);

  always_ff @(posedge CLK) begin
    if (commit) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      COUNT       <= '0;
      Q           <= '0;
      EMPTY       <= 1'b1;
      ALMOSTEMPTY <= 1'b1;
      FULL        <= 1'b0;
      ALMOSTFULL  <= 1'b0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        Q      <= mem[rd_ptr];
      end
      COUNT       <= count_nxt;
      EMPTY       <= (count_nxt == '0);
      FULL        <= (count_nxt == CW'(DEPTH));
      ALMOSTEMPTY <= (count_nxt <= CW'(ALMOST_EMPTY_VALUE));
      ALMOSTFULL  <= (count_nxt >= CW'(DEPTH - ALMOST_FULL_VALUE));
      // A fresh error outranks a same-cycle clear.
      OVERFLOW    <= (WREN & FULL) | (OVERFLOW & ~CLR_ERR);
      UNDERFLOW   <= (RDEN & EMPTY) | (UNDERFLOW & ~CLR_ERR);
    end
  end

endmodule
